// File: rtl/fp_div_issue_queue_if.sv
// fp_div_issue_queue_if: bundles the operand, divider and result handshakes of fp_div_issue_queue.
//   operand side : iA, iB, iValid -> oReady
//   divider side : oDivA, oDivB, oDivValid -> iDivDone, iDivZ
//   result side  : oZ, oValid, oDivByZero, oInvalid, oTimeout -> iReady
//   slave modport is the queue, master modport is the surrounding logic.
interface fp_div_issue_queue_if;
   logic [31:0] iA;
   logic [31:0] iB;
   logic        iValid;
   logic        oReady;
   logic [31:0] oDivA;
   logic [31:0] oDivB;
   logic        oDivValid;
   logic        iDivDone;
   logic [31:0] iDivZ;
   logic [31:0] oZ;
   logic        oValid;
   logic        iReady;
   logic        oDivByZero;
   logic        oInvalid;
   logic        oTimeout;
   modport slave (
      input  iA, iB, iValid, iDivDone, iDivZ, iReady,
      output oReady, oDivA, oDivB, oDivValid, oZ, oValid, oDivByZero, oInvalid, oTimeout
   );
   modport master (
      output iA, iB, iValid, iDivDone, iDivZ, iReady,
      input  oReady, oDivA, oDivB, oDivValid, oZ, oValid, oDivByZero, oInvalid, oTimeout
   );
endinterface

// File: rtl/fp_div_issue_queue.sv
// fp_div_issue_queue: FIFO front-end for a non-pipelined fp divider, resolving special operands locally.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   io     : slave side of fp_div_issue_queue_if (operand push, divider request/done, result handshake)
module fp_div_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input logic           clk,
   input logic           resetn,
   fp_div_issue_queue_if.slave io
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t        state, stateNext;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [CW-1:0] count;
   logic [TW-1:0] waitCnt;
   logic          push, pop, full, timeoutHit;
   logic [31:0]   headA, headB;
   logic          sign, nanA, nanB, infA, infB, zeroA, zeroB, special;
   logic [31:0]   specZ;
   logic          specDbz, specInv;
   assign full       = count == CW'(DEPTH);
   assign io.oReady  = !full;
   assign push       = io.iValid && !full;
   assign {headA, headB} = mem[rdPtr];
   assign io.oDivValid = state == ISSUE;
   assign io.oValid    = state == RESP;
   // waitCnt counts completed WAIT cycles, so this is the TIMEOUT-th WAIT cycle
   assign timeoutHit = waitCnt == TW'(TIMEOUT - 1);
   assign sign  = headA[31] ^ headB[31];
   assign nanA  = &headA[30:23] && |headA[22:0];
   assign nanB  = &headB[30:23] && |headB[22:0];
   assign infA  = &headA[30:23] && !(|headA[22:0]);
   assign infB  = &headB[30:23] && !(|headB[22:0]);
   assign zeroA = !(|headA[30:23]);
   assign zeroB = !(|headB[30:23]);
   assign special = nanA || nanB || infA || infB || zeroA || zeroB;
   // after the invalid cases, a zero divisor or infinite dividend gives Inf; all other specials give zero
   always_comb begin
      specZ   = {sign, 31'h0};
      specDbz = 1'b0;
      specInv = 1'b0;
      if (nanA || nanB || (zeroA && zeroB) || (infA && infB)) begin
         specZ   = 32'h7FC0_0000;
         specInv = 1'b1;
      end else if (zeroB || infA) begin
         specZ   = {sign, 31'h7F80_0000};
         specDbz = zeroB && !infA;
      end
   end
   always_comb begin
      stateNext = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            pop       = count != '0;
            stateNext = count == '0 ? IDLE : (special ? RESP : ISSUE);
         end
         ISSUE:   stateNext = WAIT;
         WAIT:    stateNext = (io.iDivDone || timeoutHit) ? RESP : WAIT;
         RESP:    stateNext = io.iReady ? IDLE : RESP;
         default: stateNext = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (push) mem[wrPtr] <= {io.iA, io.iB};
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         wrPtr         <= '0;
         rdPtr         <= '0;
         count         <= '0;
         waitCnt       <= '0;
         io.oDivA      <= '0;
         io.oDivB      <= '0;
         io.oZ         <= '0;
         io.oDivByZero <= 1'b0;
         io.oInvalid   <= 1'b0;
         io.oTimeout   <= 1'b0;
      end else begin
         state   <= stateNext;
         wrPtr   <= push ? wrPtr + 1'b1 : wrPtr;
         rdPtr   <= pop ? rdPtr + 1'b1 : rdPtr;
         count   <= count + CW'(push) - CW'(pop);
         waitCnt <= state == WAIT ? waitCnt + 1'b1 : '0;
         if (pop && special) begin
            io.oZ         <= specZ;
            io.oDivByZero <= specDbz;
            io.oInvalid   <= specInv;
            io.oTimeout   <= 1'b0;
         end
         if (pop && !special) begin
            io.oDivA <= headA;
            io.oDivB <= headB;
         end
         // a done pulse on the timeout cycle still delivers the real quotient
         if (state == WAIT && (io.iDivDone || timeoutHit)) begin
            io.oZ         <= io.iDivDone ? io.iDivZ : 32'h7FC0_0000;
            io.oDivByZero <= 1'b0;
            io.oInvalid   <= !io.iDivDone;
            io.oTimeout   <= !io.iDivDone;
         end
      end
   end
endmodule
